// File: rtl/serial_tx_reg.sv
// Parallel-load UART-style transmitter: start bit, WIDTH data bits LSB first,
// optional even parity, stop bit. tx idles high and is always driven from a flop.
module serial_tx_reg #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 10417,
    parameter int PARITY_EN  = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic             par_bit;
    logic             bit_end;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    assign bit_end = (cyc_cnt == CYC_LAST);

    // The cycle counter only runs outside IDLE so every bit period starts
    // on the edge that changed tx, keeping transitions on k + n*BIT_CYCLES.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            par_bit <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == IDLE || bit_end) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (en) begin
                        sreg    <= D;
                        par_bit <= even_parity(D);
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= sreg[0];
                        sreg    <= sreg >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx      <= sreg[0];
                            sreg    <= sreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
